// File: rtl/fp_sqrt_datapath.sv
// rtl/fp_sqrt_datapath.sv - single-precision square-root datapath driven by an external sequencer
module fp_sqrt_datapath (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] control_signal,
  input  logic [31:0] data_i,
  output logic        negative,
  output logic [31:0] data_o,
  output logic        done,
  output logic        invalid
);

  // Control word decode; bits 13:11 are reserved.
  logic ld_in, ld_exp, ld_rad, shift_in, ld_trial, commit, reject;
  logic ld_out, done_set, done_clr, clr_all;
  logic unused_ctrl;

  assign ld_in       = control_signal[0];
  assign ld_exp      = control_signal[1];
  assign ld_rad      = control_signal[2];
  assign shift_in    = control_signal[3];
  assign ld_trial    = control_signal[4];
  assign commit      = control_signal[5];
  assign reject      = control_signal[6];
  assign ld_out      = control_signal[7];
  assign done_set    = control_signal[8];
  assign done_clr    = control_signal[9];
  assign clr_all     = control_signal[10];
  assign unused_ctrl = ^control_signal[13:11];

  // State registers and their next-state values.
  logic [31:0] a_q, a_d;
  logic [7:0]  e_q, e_d;
  logic [47:0] d_q, d_d;
  logic [25:0] rem_q, rem_d;
  logic [23:0] q_q, q_d;
  logic [26:0] t_q, t_d;
  logic [31:0] data_q, data_d;
  logic        done_q, done_d;
  logic        invalid_q, invalid_d;

  // Derived values, all computed from pre-edge register contents.
  logic [8:0]  exp_sum;
  logic [24:0] rad_r;
  logic [26:0] trial_diff;
  logic [7:0]  a_exp;
  logic [22:0] a_man;

  assign a_exp      = a_q[30:23];
  assign a_man      = a_q[22:0];
  // Halve the biased exponent; an even unbiased exponent (odd biased) rounds up via A[23].
  assign exp_sum    = {1'b0, a_exp} + 9'd126 + {8'd0, a_q[23]};
  // Odd unbiased exponent: pre-shift the significand left by one so the root exponent is integral.
  assign rad_r      = a_q[23] ? {2'b01, a_man} : {1'b1, a_man, 1'b0};
  assign trial_diff = {1'b0, rem_q} - {1'b0, q_q, 2'b01};

  assign negative = t_q[26];
  assign data_o   = data_q;
  assign done     = done_q;
  assign invalid  = invalid_q;

  // Next-state selection; later assignments encode priority (ld_rad over shift/commit, clr_all over all).
  always_comb begin
    a_d       = a_q;
    e_d       = e_q;
    d_d       = d_q;
    rem_d     = rem_q;
    q_d       = q_q;
    t_d       = t_q;
    data_d    = data_q;
    done_d    = done_q;
    invalid_d = invalid_q;

    if (ld_in)  a_d = data_i;
    if (ld_exp) e_d = exp_sum[8:1];

    if (shift_in) begin
      rem_d = {rem_q[23:0], d_q[47:46]};
      d_d   = {d_q[45:0], 2'b00};
    end

    if (ld_trial) t_d = trial_diff;

    if (commit) begin
      rem_d = t_q[25:0];
      q_d   = {q_q[22:0], 1'b1};
    end else if (reject) begin
      q_d   = {q_q[22:0], 1'b0};
    end

    if (ld_rad) begin
      d_d   = {rad_r, 23'd0};
      rem_d = '0;
      q_d   = '0;
    end

    if (ld_out) begin
      if (a_exp == 8'd0) begin
        data_d    = {a_q[31], 31'd0};
        invalid_d = 1'b0;
      end else if (a_exp == 8'hFF && a_man != 23'd0) begin
        data_d    = 32'h7FC0_0000;
        invalid_d = 1'b1;
      end else if (a_q[31]) begin
        data_d    = 32'h7FC0_0000;
        invalid_d = 1'b1;
      end else if (a_exp == 8'hFF) begin
        data_d    = 32'h7F80_0000;
        invalid_d = 1'b0;
      end else begin
        data_d    = {1'b0, e_q, q_q[22:0]};
        invalid_d = 1'b0;
      end
    end

    if (done_set) done_d = 1'b1;
    if (done_clr) done_d = 1'b0;

    if (clr_all) begin
      a_d       = '0;
      e_d       = '0;
      d_d       = '0;
      rem_d     = '0;
      q_d       = '0;
      t_d       = '0;
      data_d    = '0;
      done_d    = 1'b0;
      invalid_d = 1'b0;
    end
  end

  // Register update with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      e_q       <= '0;
      d_q       <= '0;
      rem_q     <= '0;
      q_q       <= '0;
      t_q       <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      e_q       <= e_d;
      d_q       <= d_d;
      rem_q     <= rem_d;
      q_q       <= q_d;
      t_q       <= t_d;
      data_q    <= data_d;
      done_q    <= done_d;
      invalid_q <= invalid_d;
    end
  end

endmodule

// File: doc/fp_sqrt_datapath.md
FP_SQRT_DATAPATH -- requirements
Module: fp_sqrt_datapath

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 (rising-edge clock); rst_n input 1 (async, active-low).
REQ-002 Ports SHALL be:
- control_signal  input  14  control word from the sqrt sequencer
- data_i  input  32  IEEE-754 single operand
- negative  output  1  sign of the trial subtraction, to sequencer
- data_o  output  32  IEEE-754 single result
- done  output  1  result-valid flag
- invalid  output  1  NaN produced by last ld_out
REQ-003 control_signal bit assignment SHALL be:
- 0 ld_in, 1 ld_exp, 2 ld_rad, 3 shift_in, 4 ld_trial, 5 commit, 6 reject
- 7 ld_out, 8 done_set, 9 done_clr, 10 clr_all
- 11-13 reserved, ignored.

Function
REQ-004 Internal registers SHALL be: A[31:0] operand, E[7:0] result exponent, D[47:0] radicand shifter, REM[25:0] partial remainder, Q[23:0] root, T[26:0] trial difference.
REQ-005 ld_in: A <= data_i.
REQ-006 ld_exp: E <= (A[30:23] + 126 + A[23]) >> 1, computed in 9 bits.
REQ-007 ld_rad: D <= {R, 23'b0} with R[24:0] = {1'b1, A[22:0], 1'b0} if A[23]=0, else {1'b0, 1'b1, A[22:0]}; REM <= 0; Q <= 0.
REQ-008 shift_in: REM <= {REM[23:0], D[47:46]}; D <= D << 2.
REQ-009 ld_trial: T <= {1'b0, REM} - {1'b0, Q[23:0], 2'b01}, truncated to 27 bits, two's complement.
REQ-010 negative SHALL equal T[26] combinationally; no other logic SHALL drive it.
REQ-011 commit: REM <= T[25:0]; Q <= {Q[22:0], 1'b1}.
REQ-012 reject: Q <= {Q[22:0], 1'b0}; REM unchanged.
REQ-013 commit and reject asserted together: commit SHALL take effect and reject SHALL be ignored.
REQ-014 All control bits SHALL act on register values from before the edge. shift_in with ld_trial in one cycle: T uses the old REM.
REQ-015 ld_rad with shift_in or commit in one cycle: ld_rad SHALL win for D, REM and Q.
REQ-016 One root bit SHALL take 3 sequencer cycles: shift_in, ld_trial, commit/reject. A full root is 24 such triples; the datapath SHALL NOT count iterations.
REQ-017 ld_out SHALL load data_o and invalid, in this priority order:
- A[30:23]=0: {A[31], 31'b0} (zero and denormals flushed), invalid <= 0
- A[30:23]=255 and A[22:0]!=0: 32'h7FC00000, invalid <= 1
- A[31]=1: 32'h7FC00000, invalid <= 1
- A[30:23]=255: 32'h7F800000, invalid <= 0
- otherwise: {1'b0, E, Q[22:0]}, invalid <= 0.
REQ-018 Rounding SHALL be truncation; the final REM is discarded.
REQ-019 done_set: done <= 1. done_clr: done <= 0. Both set: done_clr SHALL win.
REQ-020 clr_all SHALL synchronously zero every register and output, overriding all other bits in that cycle.

Reset
REQ-021 rst_n low SHALL immediately clear A, E, D, REM, Q, T, data_o, done and invalid to 0; negative is then 0.
REQ-022 Reset mid-root SHALL abandon the operation; no partial result SHALL appear on data_o.
REQ-023 Only after rst_n deasserts SHALL the first rising clk edge act on control_signal.

Verification
REQ-024 0x40800000 (4.0), full sequence -> data_o=0x40000000, invalid=0, done=1 after done_set.
REQ-025 0x40000000 (2.0) -> data_o=0x3FB504F3; 0x3E800000 (0.25) -> 0x3F000000.
REQ-026 Special inputs at ld_out:
- 0xBF800000 -> 0x7FC00000, invalid=1
- 0x7F800000 -> 0x7F800000
- 0x80000000 -> 0x80000000
- 0x7FC00001 -> 0x7FC00000, invalid=1
REQ-027 First triple for 1.0 (0x3F800000): after shift_in+ld_trial, negative=0 (T=0); after commit, Q=1, REM=0.
REQ-028 Conflicts: commit+reject -> Q LSB=1; done_set+done_clr -> done=0; clr_all with ld_in -> A=0.
REQ-029 Reset mid-operation: rst_n low at iteration 10 -> all outputs 0 at once; a fresh 9.0 (0x41100000) -> 0x40400000.
